// File: rtl/dmem_responder.sv
// Single-port 16-bit word memory behind a fixed-latency request/ready handshake.
// One request in flight; the op, index and write data are captured at acceptance.
module dmem_responder #(
    parameter int LATENCY   = 2,
    parameter int ADDR_BITS = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        readM,
    input  logic        writeM,
    input  logic [15:0] address,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        ready,
    output logic        busy,
    output logic        err
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    typedef struct packed {
        logic                 wr;
        logic [ADDR_BITS-1:0] idx;
        logic [15:0]          wdata;
    } req_t;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t     state, state_n;
    logic [3:0] cnt, cnt_n;
    req_t       req;
    logic       accept, commit;
    logic [15:0] mem [0:(2**ADDR_BITS)-1];

    // Upper address bits alias onto the same storage.
    logic unused_addr_hi;
    assign unused_addr_hi = ^address[15:ADDR_BITS];

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        accept  = 1'b0;
        commit  = 1'b0;
        case (state)
            IDLE: if (readM || writeM) begin
                accept  = 1'b1;
                cnt_n   = CNT_INIT;
                state_n = WAIT;
            end
            WAIT: if (cnt != 4'd0) begin
                cnt_n = cnt - 4'd1;
            end else begin
                commit  = 1'b1;
                state_n = DONE;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            req      <= '0;
            ready    <= 1'b0;
            err      <= 1'b0;
            data_out <= 16'h0000;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            ready <= commit;
            // A simultaneous read+write is serviced as a write and flagged.
            err   <= accept && readM && writeM;
            if (accept)
                req <= '{wr: writeM, idx: address[ADDR_BITS-1:0], wdata: data_in};
            if (commit && !req.wr)
                data_out <= mem[req.idx];
        end
    end

    // Storage survives reset; an aborted write never reaches commit.
    always_ff @(posedge clk) begin
        if (commit && req.wr)
            mem[req.idx] <= req.wdata;
    end

    assign busy = (state != IDLE);
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=2 instance for the main table and
// sequences, LATENCY=1 instance for the input-latching case.
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        rd2 = 1'b0, wr2 = 1'b0, rd1 = 1'b0, wr1 = 1'b0;
    logic [15:0] a2 = '0, d2 = '0, a1 = '0, d1 = '0;
    logic [15:0] q2, q1;
    logic        rdy2, bsy2, err2, rdy1, bsy1, err1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dmem_responder #(.LATENCY(2), .ADDR_BITS(8)) u2 (
        .clk(clk), .reset_n(reset_n), .readM(rd2), .writeM(wr2),
        .address(a2), .data_in(d2), .data_out(q2),
        .ready(rdy2), .busy(bsy2), .err(err2));

    dmem_responder #(.LATENCY(1), .ADDR_BITS(8)) u1 (
        .clk(clk), .reset_n(reset_n), .readM(rd1), .writeM(wr1),
        .address(a1), .data_in(d1), .data_out(q1),
        .ready(rdy1), .busy(bsy1), .err(err1));

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] din;
        logic [15:0] exp_dout;
        logic        exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One request on the selected instance; inputs are scrambled right after
    // acceptance so any late sampling shows up as wrong data.
    task automatic do_op(input bit sel, input logic rd, input logic wr,
                         input logic [15:0] addr, input logic [15:0] din,
                         output int lat, output logic err_acc,
                         output logic busy_rdy, output logic [15:0] dout);
        @(negedge clk);
        if (sel) begin rd1 = rd; wr1 = wr; a1 = addr; d1 = din; end
        else     begin rd2 = rd; wr2 = wr; a2 = addr; d2 = din; end
        @(posedge clk); #1;
        err_acc = sel ? err1 : err2;
        if (sel) begin rd1 = 0; wr1 = 0; a1 = addr ^ 16'h00FF; d1 = ~din; end
        else     begin rd2 = 0; wr2 = 0; a2 = addr ^ 16'h00FF; d2 = ~din; end
        lat = 99;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (sel ? rdy1 : rdy2) begin
                lat = i;
                break;
            end
        end
        dout     = sel ? q1 : q2;
        busy_rdy = sel ? bsy1 : bsy2;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          lat;
        logic        e, b;
        logic [15:0] q;

        vecs[0] = '{rd: 0, wr: 1, addr: 16'h0005, din: 16'h1234, exp_dout: 16'h0000, exp_err: 0};
        vecs[1] = '{rd: 1, wr: 0, addr: 16'h0005, din: 16'h0000, exp_dout: 16'h1234, exp_err: 0};
        vecs[2] = '{rd: 0, wr: 1, addr: 16'h0103, din: 16'hBEEF, exp_dout: 16'h1234, exp_err: 0};
        vecs[3] = '{rd: 1, wr: 0, addr: 16'h0003, din: 16'h0000, exp_dout: 16'hBEEF, exp_err: 0};
        vecs[4] = '{rd: 1, wr: 1, addr: 16'h0007, din: 16'h00AA, exp_dout: 16'hBEEF, exp_err: 1};
        vecs[5] = '{rd: 1, wr: 0, addr: 16'h0007, din: 16'h0000, exp_dout: 16'h00AA, exp_err: 0};
        vecs[6] = '{rd: 0, wr: 1, addr: 16'h0009, din: 16'h1111, exp_dout: 16'h00AA, exp_err: 0};
        vecs[7] = '{rd: 1, wr: 0, addr: 16'h0109, din: 16'h0000, exp_dout: 16'h1111, exp_err: 0};

        // Reset state
        #12;
        check("reset ready", 32'(rdy2), 32'h0);
        check("reset busy",  32'(bsy2), 32'h0);
        check("reset err",   32'(err2), 32'h0);
        check("reset dout",  32'(q2),   32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            do_op(1'b0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].din, lat, e, b, q);
            check($sformatf("vec%0d err", i),  32'(e),   32'(vecs[i].exp_err));
            check($sformatf("vec%0d lat", i),  32'(lat), 32'd2);
            check($sformatf("vec%0d dout", i), 32'(q),   32'(vecs[i].exp_dout));
            check($sformatf("vec%0d busy@rdy", i), 32'(b), 32'h1);
            check($sformatf("vec%0d ready drop", i), 32'(rdy2), 32'h0);
            check($sformatf("vec%0d idle", i), 32'(bsy2), 32'h0);
        end

        // readM held: WAIT,WAIT,DONE,IDLE repeating; accept edges 1,5,9
        @(negedge clk);
        rd2 = 1'b1; a2 = 16'h0005;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            check($sformatf("held k%0d busy", k),  32'(bsy2), 32'((k % 4) != 0));
            check($sformatf("held k%0d ready", k), 32'(rdy2), 32'((k % 4) == 3));
            if ((k % 4) == 3)
                check($sformatf("held k%0d dout", k), 32'(q2), 32'h1234);
        end
        rd2 = 1'b0;

        // Reset during WAIT aborts a write
        @(negedge clk);
        wr2 = 1'b1; a2 = 16'h0009; d2 = 16'h5555;
        @(posedge clk); #1;
        wr2 = 1'b0;
        check("abort busy in WAIT", 32'(bsy2), 32'h1);
        #2 reset_n = 1'b0;
        #1;
        check("abort ready", 32'(rdy2), 32'h0);
        check("abort busy",  32'(bsy2), 32'h0);
        check("abort err",   32'(err2), 32'h0);
        check("abort dout",  32'(q2),   32'h0);
        @(posedge clk); #1;
        check("abort hold ready", 32'(rdy2), 32'h0);
        @(posedge clk); #2;
        reset_n = 1'b1;
        // First edge after release accepts
        do_op(1'b0, 1'b1, 1'b0, 16'h0009, 16'h0000, lat, e, b, q);
        check("post-reset lat",  32'(lat), 32'd2);
        check("post-reset dout", 32'(q),   32'h1111);

        // LATENCY=1: inputs change the cycle after acceptance
        do_op(1'b1, 1'b0, 1'b1, 16'h0021, 16'h7777, lat, e, b, q);
        check("lat1 prewrite lat", 32'(lat), 32'd1);
        @(negedge clk);
        wr1 = 1'b1; a1 = 16'h0020; d1 = 16'hCAFE;
        @(posedge clk); #1;
        check("lat1 accept ready", 32'(rdy1), 32'h0);
        check("lat1 accept busy",  32'(bsy1), 32'h1);
        @(negedge clk);
        a1 = 16'h0021; d1 = 16'hDEAD;
        @(posedge clk); #1;
        check("lat1 ready", 32'(rdy1), 32'h1);
        wr1 = 1'b0;
        @(posedge clk); #1;
        check("lat1 idle", 32'(bsy1), 32'h0);
        do_op(1'b1, 1'b1, 1'b0, 16'h0020, 16'h0000, lat, e, b, q);
        check("lat1 read20 lat",  32'(lat), 32'd1);
        check("lat1 read20 dout", 32'(q),   32'hCAFE);
        do_op(1'b1, 1'b1, 1'b0, 16'h0021, 16'h0000, lat, e, b, q);
        check("lat1 read21 dout", 32'(q),   32'h7777);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
